// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host/device paths: FSM encoding, command
// bytes and the frame parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_FAIL
  } state_t;

  localparam logic [7:0] PS2_CMD_LED       = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET     = 8'hFF;
  localparam logic [7:0] PS2_CMD_TYPEMATIC = 8'hF3;
  localparam logic [7:0] PS2_ACK           = 8'hFA;

  // PS/2 frames carry odd parity: data bits plus parity bit have an odd count of ones.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one PS/2 line plus a one-cycle falling-edge strobe
// derived from the synchronized level.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic sync,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = pin;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // NOTE: reset to 1 (the idle bus level) so leaving reset never fakes a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync = sync_q;
  assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibits the bus, requests to send,
// shifts one byte plus odd parity on device clock edges and checks the ack.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int START_TIMEOUT  = 375000,
  parameter int XFER_TIMEOUT   = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       kbd_clk_in,
  input  logic       kbd_data_in,
  output logic       kbd_clk_oe,
  output logic       kbd_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CNT_MAX = max3(START_TIMEOUT, INHIBIT_CYCLES, XFER_TIMEOUT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bitn_q, bitn_d;
  logic [7:0]       sh_q, sh_d;
  logic             par_q, par_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic       clk_sync, clk_fall;
  logic       data_sync, data_fall_unused;
  logic [8:0] frame_d;

  ps2_sync_edge u_clk_sync (
    .clk  (clk),
    .rst  (rst),
    .pin  (kbd_clk_in),
    .sync (clk_sync),
    .fall (clk_fall)
  );

  ps2_sync_edge u_data_sync (
    .clk  (clk),
    .rst  (rst),
    .pin  (kbd_data_in),
    .sync (data_sync),
    .fall (data_fall_unused)
  );

  // State register: all state and every output is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bitn_q    <= '0;
      sh_q      <= '0;
      par_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitn_q    <= bitn_d;
      sh_q      <= sh_d;
      par_q     <= par_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic. A device edge always takes priority over an expiring
  // counter; the transfer timeout spans the whole frame, not each bit.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    bitn_d  = bitn_q;
    sh_d    = sh_q;
    par_d   = par_q;

    if (state_q != ST_IDLE && state_q != ST_FAIL) cnt_d = cnt_q - CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          state_d = ST_INHIBIT;
          cnt_d   = CNT_W'(INHIBIT_CYCLES - 1);
          sh_d    = tx_data;
          par_d   = odd_parity(tx_data);
        end
      end
      ST_INHIBIT: begin
        if (cnt_q == '0) begin
          state_d = ST_REQ;
          cnt_d   = CNT_W'(START_TIMEOUT - 1);
        end
      end
      ST_REQ: begin
        if (clk_fall) begin
          state_d = ST_SEND;
          bitn_d  = 4'd1;
          cnt_d   = CNT_W'(XFER_TIMEOUT - 1);
        end else if (cnt_q == '0) begin
          state_d = ST_FAIL;
        end
      end
      ST_SEND: begin
        if (clk_fall) begin
          bitn_d = bitn_q + 4'd1;
          if (bitn_q == 4'd9) state_d = ST_ACK;
        end else if (cnt_q == '0) begin
          state_d = ST_FAIL;
        end
      end
      ST_ACK: begin
        if (clk_fall) state_d = data_sync ? ST_FAIL : ST_WAIT_IDLE;
        else if (cnt_q == '0) state_d = ST_FAIL;
      end
      ST_WAIT_IDLE: begin
        if (clk_sync && data_sync) state_d = ST_IDLE;
        else if (cnt_q == '0) state_d = ST_FAIL;
      end
      ST_FAIL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic, decoded from the next state so the pins change together
  // with the state they belong to. In SEND, bit index bitn-1 is on the line
  // (0..7 data, 8 parity).
  assign frame_d = {par_d, sh_d};

  always_comb begin
    clk_oe_d  = (state_d == ST_INHIBIT);
    data_oe_d = 1'b0;
    done_d    = (state_q == ST_WAIT_IDLE) && (state_d == ST_IDLE);
    err_d     = (state_d == ST_FAIL);
    case (state_d)
      ST_REQ:  data_oe_d = 1'b1;
      ST_SEND: data_oe_d = ~frame_d[bitn_d - 4'd1];
      default: data_oe_d = 1'b0;
    endcase
  end

  assign tx_ready    = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign kbd_clk_oe  = clk_oe_q;
  assign kbd_data_oe = data_oe_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain bus with a behavioural keyboard that
// clocks frames in, checked against a frame model built from the PS/2 rules.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int STO = 100;
  localparam int XTO = 600;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       kbd_clk_in, kbd_data_in;
  logic       kbd_clk_oe, kbd_data_oe;
  logic       busy, done, err;

  int vectors = 0;
  int miscompares = 0;

  // Monitor state
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   pulse_bad = 0;
  logic done_prev = 1'b0;
  logic err_prev = 1'b0;
  logic busy_prev = 1'b0;
  logic after_done_clk_oe = 1'b0;

  // Wired-AND open-drain bus: either side can pull a line low.
  assign kbd_clk_in  = dev_clk & ~kbd_clk_oe;
  assign kbd_data_in = dev_data & ~kbd_data_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .START_TIMEOUT  (STO),
    .XFER_TIMEOUT   (XTO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .kbd_clk_in  (kbd_clk_in),
    .kbd_data_in (kbd_data_in),
    .kbd_clk_oe  (kbd_clk_oe),
    .kbd_data_oe (kbd_data_oe),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  // done must be one cycle wide and land exactly when busy falls; err one cycle wide.
  always @(negedge clk) begin
    if (done_prev) after_done_clk_oe = kbd_clk_oe;
    if (done) begin
      done_cnt++;
      if (done_prev || busy || !busy_prev) pulse_bad++;
    end
    if (err) begin
      err_cnt++;
      if (err_prev) pulse_bad++;
    end
    done_prev = done;
    err_prev  = err;
    busy_prev = busy;
  end

  // Expected 11-bit frame on the wire, index 0 = start ... 10 = stop.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    int   ones;
    logic par;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    par = (ones % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic start_tx(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Keyboard model: waits out the inhibit, then produces n_edges clock pulses,
  // reading the host's bit 3 cycles after each falling edge.
  task automatic run_frame(input logic ack_bit, input int half, input int n_edges,
                           output logic [10:0] got, output int inh_len, output bit ok);
    int t;
    ok = 1'b1;
    got = '1;
    inh_len = 0;
    t = 0;
    while (!kbd_clk_oe && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!kbd_clk_oe) begin
      ok = 1'b0;
      return;
    end
    t = 0;
    while (kbd_clk_oe && t < 5000) begin
      inh_len++;
      @(negedge clk);
      t++;
    end
    got[0] = kbd_data_in;
    repeat ($urandom_range(20, 3)) @(negedge clk);
    for (int e = 1; e <= n_edges; e++) begin
      dev_clk = 1'b0;
      repeat (3) @(negedge clk);
      if (e <= 10) got[e] = kbd_data_in;
      repeat (half - 3) @(negedge clk);
      dev_clk = 1'b1;
      if (e == 10) dev_data = ack_bit;
      if (e == 11) dev_data = 1'b1;
      repeat (half) @(negedge clk);
    end
  endtask

  task automatic wait_pulse(input int d0, input int e0);
    int t;
    t = 0;
    while (done_cnt == d0 && err_cnt == e0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (kbd_clk_oe !== 1'b0) begin miscompares++; $display("FAIL reset_clk_oe: got %b want 0", kbd_clk_oe); end
    vectors++; if (kbd_data_oe !== 1'b0) begin miscompares++; $display("FAIL reset_data_oe: got %b want 0", kbd_data_oe); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_frame(input string name, input logic [7:0] b, input int half);
    logic [10:0] got, exp;
    int inh, d0, e0, pb;
    bit ok;
    d0 = done_cnt; e0 = err_cnt; pb = pulse_bad;
    exp = model_frame(b);
    start_tx(b);
    run_frame(1'b0, half, 11, got, inh, ok);
    wait_pulse(d0, e0);
    vectors++; if (!ok) begin miscompares++; $display("FAIL %s_inhibit_seen: host never pulled clock low", name); end
    vectors++; if (inh != INH) begin miscompares++; $display("FAIL %s_inhibit_len: got %0d want %0d", name, inh, INH); end
    vectors++; if (got !== exp) begin miscompares++; $display("FAIL %s_frame: got %b want %b", name, got, exp); end
    vectors++; if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL %s_done_count: got %0d want 1", name, done_cnt - d0); end
    vectors++; if (err_cnt != e0) begin miscompares++; $display("FAIL %s_err_count: got %0d want 0", name, err_cnt - e0); end
    vectors++; if (pulse_bad != pb) begin miscompares++; $display("FAIL %s_pulse_shape: got %0d bad pulses want 0", name, pulse_bad - pb); end
    vectors++; if (busy !== 1'b0 || tx_ready !== 1'b1) begin miscompares++; $display("FAIL %s_idle_after: busy %b ready %b want 0 1", name, busy, tx_ready); end
  endtask

  task automatic test_zero();
    logic [10:0] got;
    int inh, d0, e0;
    bit ok;
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'h00);
    run_frame(1'b0, 7, 11, got, inh, ok);
    wait_pulse(d0, e0);
    vectors++; if (got[8:1] !== 8'h00) begin miscompares++; $display("FAIL zero_data: got %h want 00", got[8:1]); end
    vectors++; if (got[9] !== 1'b1) begin miscompares++; $display("FAIL zero_parity: got %b want 1", got[9]); end
    vectors++; if (got[10] !== 1'b1) begin miscompares++; $display("FAIL zero_stop_released: got %b want 1", got[10]); end
    vectors++; if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL zero_done: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      test_frame($sformatf("rand%0d", i), 8'($urandom), int'($urandom_range(12, 5)));
    end
  endtask

  task automatic test_no_clock();
    int t, k, d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hF3);
    t = 0;
    while (kbd_clk_oe && t < 200) begin
      @(negedge clk);
      t++;
    end
    k = 0;
    while (!err && k < 300) begin
      @(negedge clk);
      k++;
    end
    vectors++; if (k != STO) begin miscompares++; $display("FAIL noclk_err_time: got %0d want %0d cycles after request", k, STO); end
    @(negedge clk);
    vectors++; if (kbd_clk_oe !== 1'b0 || kbd_data_oe !== 1'b0) begin miscompares++; $display("FAIL noclk_oe: got %b%b want 00", kbd_clk_oe, kbd_data_oe); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL noclk_busy: got %b want 0", busy); end
    vectors++; if (err_cnt - e0 != 1 || done_cnt != d0) begin miscompares++; $display("FAIL noclk_pulses: err %0d done %0d want 1 0", err_cnt - e0, done_cnt - d0); end
  endtask

  task automatic test_high_ack();
    logic [10:0] got, exp;
    int inh, d0, e0;
    bit ok;
    d0 = done_cnt; e0 = err_cnt;
    exp = model_frame(8'hFF);
    start_tx(8'hFF);
    run_frame(1'b1, 8, 11, got, inh, ok);
    wait_pulse(d0, e0);
    vectors++; if (got !== exp) begin miscompares++; $display("FAIL nack_frame: got %b want %b", got, exp); end
    vectors++; if (err_cnt - e0 != 1) begin miscompares++; $display("FAIL nack_err: got %0d want 1", err_cnt - e0); end
    vectors++; if (done_cnt != d0) begin miscompares++; $display("FAIL nack_done: got %0d want 0", done_cnt - d0); end
    vectors++; if (busy !== 1'b0 || kbd_data_oe !== 1'b0) begin miscompares++; $display("FAIL nack_idle: busy %b data_oe %b want 0 0", busy, kbd_data_oe); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  a, b2;
    logic [10:0] got1, got2;
    int inh, d0, e0;
    bit ok1, ok2;
    a  = 8'($urandom);
    b2 = a ^ 8'($urandom_range(255, 1));
    d0 = done_cnt; e0 = err_cnt;
    after_done_clk_oe = 1'b0;
    @(negedge clk);
    tx_data  = a;
    tx_valid = 1'b1;
    @(negedge clk);
    fork
      run_frame(1'b0, 8, 11, got1, inh, ok1);
      begin
        repeat (80) @(negedge clk);
        tx_data = b2;
      end
    join
    tx_valid = 1'b0;
    vectors++; if (after_done_clk_oe !== 1'b1) begin miscompares++; $display("FAIL b2b_second_start: clk_oe after done %b want 1", after_done_clk_oe); end
    run_frame(1'b0, 8, 11, got2, inh, ok2);
    wait_pulse(d0 + 1, e0);
    vectors++; if (got1 !== model_frame(a)) begin miscompares++; $display("FAIL b2b_first_frame: got %b want %b", got1, model_frame(a)); end
    vectors++; if (got2 !== model_frame(b2)) begin miscompares++; $display("FAIL b2b_second_frame: got %b want %b", got2, model_frame(b2)); end
    vectors++; if (done_cnt - d0 != 2 || err_cnt != e0) begin miscompares++; $display("FAIL b2b_pulses: done %0d err %0d want 2 0", done_cnt - d0, err_cnt - e0); end
  endtask

  task automatic test_busy_ignore();
    logic [7:0]  b;
    logic [10:0] got;
    int inh, d0, e0, restarts;
    bit ok;
    b = 8'($urandom);
    d0 = done_cnt; e0 = err_cnt;
    start_tx(b);
    fork
      run_frame(1'b0, 6, 11, got, inh, ok);
      begin
        repeat (60) @(negedge clk);
        tx_data  = ~b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    wait_pulse(d0, e0);
    restarts = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy || kbd_clk_oe) restarts++;
    end
    vectors++; if (got !== model_frame(b)) begin miscompares++; $display("FAIL ignore_frame: got %b want %b", got, model_frame(b)); end
    vectors++; if (restarts != 0) begin miscompares++; $display("FAIL ignore_no_queue: got %0d busy cycles want 0", restarts); end
  endtask

  task automatic test_reset_mid();
    logic [7:0]  b;
    logic [10:0] got, exp;
    int inh, d0, e0;
    bit ok;
    b = 8'($urandom);
    exp = model_frame(b);
    d0 = done_cnt; e0 = err_cnt;
    start_tx(b);
    run_frame(1'b0, 8, 4, got, inh, ok);
    vectors++; if (got[4:0] !== exp[4:0]) begin miscompares++; $display("FAIL rstmid_bits: got %b want %b", got[4:0], exp[4:0]); end
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (kbd_clk_oe !== 1'b0 || kbd_data_oe !== 1'b0) begin miscompares++; $display("FAIL rstmid_oe: got %b%b want 00", kbd_clk_oe, kbd_data_oe); end
    vectors++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_ready: ready %b busy %b want 1 0", tx_ready, busy); end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    vectors++; if (done_cnt != d0 || err_cnt != e0) begin miscompares++; $display("FAIL rstmid_pulses: done %0d err %0d want 0 0", done_cnt - d0, err_cnt - e0); end
  endtask

  initial begin
    test_reset();
    test_frame("led", 8'hED, 10);
    test_zero();
    test_random();
    test_no_clock();
    test_high_ack();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
